// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// FN3 load/store size codes match the memory's fn3 decode.
package dmem_arb_pkg;

    typedef enum logic {IDLE, RD_RESP} arb_state_t;
    typedef enum logic {M_CPU, M_AUX} arb_id_t;

    localparam int STARVE_MAX_DEF = 8;
    localparam int STARVE_W       = $clog2(STARVE_MAX_DEF + 1);

    localparam logic [2:0] FN3_LB  = 3'b000;
    localparam logic [2:0] FN3_LH  = 3'b001;
    localparam logic [2:0] FN3_LW  = 3'b010;
    localparam logic [2:0] FN3_LBU = 3'b100;
    localparam logic [2:0] FN3_LHU = 3'b101;
    localparam logic [2:0] FN3_SB  = 3'b000;
    localparam logic [2:0] FN3_SH  = 3'b001;
    localparam logic [2:0] FN3_SW  = 3'b010;

endpackage

// File: rtl/dmem_port_arbiter_prio.sv
// Grant decision between the CPU (m0) and the aux master (m1), with a
// starvation counter that forces m1 through after STARVE_MAX lost cycles.
module dmem_arb_prio #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_idle,
    input  logic m0_valid,
    input  logic m1_valid,
    output logic grant_valid,
    output logic grant_aux
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;
    logic          force_m1;
    logic          m1_acc;

    always_comb begin
        force_m1    = m1_valid && (starve_cnt == CW'(STARVE_MAX));
        grant_aux   = m1_valid && (!m0_valid || force_m1);
        grant_valid = in_idle && (m0_valid || m1_valid);
        m1_acc      = grant_valid && grant_aux;
    end

    // Counts every cycle m1 waits, RD_RESP cycles included, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!m1_valid || m1_acc) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single data-memory port. Stores issue every
// cycle; loads occupy issue + response cycle so fn3/addr stay stable for formatting.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req_valid,
    output logic          m0_req_ready,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic          m0_we,
    input  logic [2:0]    m0_fn3,
    output logic          m0_rsp_valid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req_valid,
    output logic          m1_req_ready,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic          m1_we,
    input  logic [2:0]    m1_fn3,
    output logic          m1_rsp_valid,
    output logic [31:0]   m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    output logic [2:0]    mem_fn3,
    input  logic [31:0]   mem_rdata
);

    arb_state_t    state, state_nxt;
    logic          in_idle;
    logic          grant_valid;
    logic          grant_aux;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic          sel_we;
    logic [2:0]    sel_fn3;
    logic [AW-1:0] ld_addr;
    logic [2:0]    ld_fn3;
    logic          rsp_pend;
    arb_id_t       rsp_id;
    logic          rsp_load;
    logic          rsp_live;

    assign in_idle = rst_n && (state == IDLE);

    dmem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_idle     (in_idle),
        .m0_valid    (m0_req_valid),
        .m1_valid    (m1_req_valid),
        .grant_valid (grant_valid),
        .grant_aux   (grant_aux)
    );

    always_comb begin
        sel_addr  = grant_aux ? m1_addr  : m0_addr;
        sel_wdata = grant_aux ? m1_wdata : m0_wdata;
        sel_we    = grant_aux ? m1_we    : m0_we;
        sel_fn3   = grant_aux ? m1_fn3   : m0_fn3;
    end

    always_comb begin
        state_nxt    = state;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        mem_fn3      = FN3_LW;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    mem_addr     = sel_addr;
                    mem_wdata    = sel_wdata;
                    mem_we       = sel_we;
                    mem_fn3      = sel_fn3;
                    m0_req_ready = !grant_aux;
                    m1_req_ready = grant_aux;
                    if (!sel_we) state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                mem_addr  = ld_addr;
                mem_fn3   = ld_fn3;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rsp_pend <= 1'b0;
            rsp_id   <= M_CPU;
            rsp_load <= 1'b0;
            ld_addr  <= '0;
            ld_fn3   <= FN3_LW;
        end else begin
            state    <= state_nxt;
            rsp_pend <= grant_valid;
            if (grant_valid) begin
                rsp_id   <= grant_aux ? M_AUX : M_CPU;
                rsp_load <= !sel_we;
                if (!sel_we) begin
                    ld_addr <= sel_addr;
                    ld_fn3  <= sel_fn3;
                end
            end
        end
    end

    // Gating with rst_n drops a response whose cycle is hit by reset.
    always_comb begin
        rsp_live     = rst_n && rsp_pend;
        m0_rsp_valid = rsp_live && (rsp_id == M_CPU);
        m1_rsp_valid = rsp_live && (rsp_id == M_AUX);
        m0_rdata     = (m0_rsp_valid && rsp_load) ? mem_rdata : 32'd0;
        m1_rdata     = (m1_rsp_valid && rsp_load) ? mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a registered-read data memory
// model and per-master expected-response queues.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 32;

    logic          clk;
    logic          rst_n;
    logic          m0_req_valid, m0_req_ready, m0_we, m0_rsp_valid;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_wdata, m0_rdata;
    logic [2:0]    m0_fn3;
    logic          m1_req_valid, m1_req_ready, m1_we, m1_rsp_valid;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata, m1_rdata;
    logic [2:0]    m1_fn3;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_we;
    logic [2:0]    mem_fn3;

    int n_checks = 0;
    int n_err    = 0;
    int rsp_cnt0 = 0;
    int rsp_cnt1 = 0;
    int base;
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    logic [31:0] mem [16];
    logic [31:0] rd_word;

    dmem_port_arbiter #(.STARVE_MAX(8), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_we        (m0_we),
        .m0_fn3       (m0_fn3),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rdata     (m0_rdata),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_we        (m1_we),
        .m1_fn3       (m1_fn3),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rdata     (m1_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_fn3      (mem_fn3),
        .mem_rdata    (mem_rdata)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: registered word read, formatted by fn3/addr of the response cycle
    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] fn3, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (fn3)
            FN3_LB:  return {{24{b[7]}}, b};
            FN3_LH:  return {{16{h[15]}}, h};
            FN3_LBU: return {24'd0, b};
            FN3_LHU: return {16'd0, h};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_fn3)
                FN3_SB:  mem[mem_addr[5:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
                FN3_SH:  mem[mem_addr[5:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
                default: mem[mem_addr[5:2]] <= mem_wdata;
            endcase
        end else begin
            rd_word <= mem[mem_addr[5:2]];
        end
    end
    assign mem_rdata = fmt(rd_word, mem_fn3, mem_addr[1:0]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_m0(input logic v, input logic we, input logic [2:0] fn3,
                            input logic [AW-1:0] addr, input logic [31:0] wdata);
        m0_req_valid = v; m0_we = we; m0_fn3 = fn3; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic drive_m1(input logic v, input logic we, input logic [2:0] fn3,
                            input logic [AW-1:0] addr, input logic [31:0] wdata);
        m1_req_valid = v; m1_we = we; m1_fn3 = fn3; m1_addr = addr; m1_wdata = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every response pulse pops the owner's queue
    always @(negedge clk) begin
        if (m0_rsp_valid) begin
            rsp_cnt0++;
            chk("m0_rsp_queued", 32'(exp0_q.size() > 0), 32'd1);
            if (exp0_q.size() > 0) chk("m0_rdata", m0_rdata, exp0_q.pop_front());
        end else begin
            chk("m0_rdata_idle", m0_rdata, 32'd0);
        end
        if (m1_rsp_valid) begin
            rsp_cnt1++;
            chk("m1_rsp_queued", 32'(exp1_q.size() > 0), 32'd1);
            if (exp1_q.size() > 0) chk("m1_rdata", m1_rdata, exp1_q.pop_front());
        end else begin
            chk("m1_rdata_idle", m1_rdata, 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'h12345678;
        mem[6] = 32'hCAFEF00D;
        rd_word = 32'd0;
        rst_n = 1'b0;
        drive_m0(1'b0, 1'b0, FN3_LW, '0, '0);
        drive_m1(1'b0, 1'b0, FN3_LW, '0, '0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_starve", 32'(dut.u_prio.starve_cnt), 32'd0);
        chk("rst_ready", {30'd0, m0_req_ready, m1_req_ready}, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_fn3", 32'(mem_fn3), 32'(FN3_LW));
        chk("rst_mem_addr", mem_addr, 32'd0);
        step();
        rst_n = 1'b1;

        // 1: m0 LW @0x10
        drive_m0(1'b1, 1'b0, FN3_LW, 32'h10, '0);
        @(negedge clk);
        chk("t1_ready", 32'(m0_req_ready), 32'd1);
        chk("t1_we_issue", 32'(mem_we), 32'd0);
        chk("t1_fn3_issue", 32'(mem_fn3), 32'(FN3_LW));
        chk("t1_addr_issue", mem_addr, 32'h10);
        if (m0_req_ready) exp0_q.push_back(32'hDEADBEEF);
        step();
        drive_m0(1'b0, 1'b0, FN3_LW, '0, '0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(m0_rsp_valid), 32'd1);
        chk("t1_state_resp", 32'(dut.state), 32'(RD_RESP));
        chk("t1_fn3_resp", 32'(mem_fn3), 32'(FN3_LW));
        chk("t1_addr_resp", mem_addr, 32'h10);
        chk("t1_ready_resp", 32'(m0_req_ready), 32'd0);
        step();
        @(negedge clk);
        chk("t1_state_back", 32'(dut.state), 32'(IDLE));

        // 2: three back-to-back SW
        base = rsp_cnt0;
        step();
        for (int i = 0; i < 3; i++) begin
            drive_m0(1'b1, 1'b1, FN3_SW, 32'(4 * i), 32'h80A1B2C3 + 32'(i));
            @(negedge clk);
            chk("t2_ready", 32'(m0_req_ready), 32'd1);
            chk("t2_mem_we", 32'(mem_we), 32'd1);
            if (m0_req_ready) exp0_q.push_back(32'd0);
            step();
        end
        drive_m0(1'b0, 1'b0, FN3_LW, '0, '0);
        step();
        chk("t2_rsp_count", 32'(rsp_cnt0 - base), 32'd3);
        chk("t2_mem0", mem[0], 32'h80A1B2C3);
        chk("t2_mem2", mem[2], 32'h80A1B2C5);

        // 3: simultaneous loads, m0 first
        drive_m0(1'b1, 1'b0, FN3_LW, 32'h10, '0);
        drive_m1(1'b1, 1'b0, FN3_LW, 32'h14, '0);
        @(negedge clk);
        chk("t3_m0_ready", 32'(m0_req_ready), 32'd1);
        chk("t3_m1_wait", 32'(m1_req_ready), 32'd0);
        if (m0_req_ready) exp0_q.push_back(32'hDEADBEEF);
        step();
        drive_m0(1'b0, 1'b0, FN3_LW, '0, '0);
        @(negedge clk);
        chk("t3_m1_wait_resp", 32'(m1_req_ready), 32'd0);
        step();
        @(negedge clk);
        chk("t3_m1_ready", 32'(m1_req_ready), 32'd1);
        if (m1_req_ready) exp1_q.push_back(32'h12345678);
        step();
        drive_m1(1'b0, 1'b0, FN3_LW, '0, '0);
        @(negedge clk);
        chk("t3_m1_rsp", 32'(m1_rsp_valid), 32'd1);
        step();

        // 4: m0 store stream vs starving m1 load
        drive_m1(1'b1, 1'b0, FN3_LW, 32'h18, '0);
        for (int i = 0; i <= 8; i++) begin
            drive_m0(1'b1, 1'b1, FN3_SW, 32'h20 + 32'(4 * i), 32'(i));
            @(negedge clk);
            chk("t4_starve", 32'(dut.u_prio.starve_cnt), 32'(i));
            chk("t4_m0_ready", 32'(m0_req_ready), 32'(i != 8));
            chk("t4_m1_ready", 32'(m1_req_ready), 32'(i == 8));
            if (m0_req_ready) exp0_q.push_back(32'd0);
            if (m1_req_ready) exp1_q.push_back(32'hCAFEF00D);
            step();
        end
        drive_m0(1'b0, 1'b0, FN3_LW, '0, '0);
        drive_m1(1'b0, 1'b0, FN3_LW, '0, '0);
        @(negedge clk);
        chk("t4_m1_rsp", 32'(m1_rsp_valid), 32'd1);
        chk("t4_starve_clr", 32'(dut.u_prio.starve_cnt), 32'd0);
        chk("t4_mem11", mem[11], 32'd3);
        step();

        // 5: m1 LB @0x3 sign-extends 0x80; m0 LHU @0x2
        drive_m1(1'b1, 1'b0, FN3_LB, 32'h3, '0);
        @(negedge clk);
        chk("t5_m1_ready", 32'(m1_req_ready), 32'd1);
        if (m1_req_ready) exp1_q.push_back(32'hFFFFFF80);
        step();
        drive_m1(1'b0, 1'b0, FN3_LW, '0, '0);
        @(negedge clk);
        chk("t5_m1_rsp", 32'(m1_rsp_valid), 32'd1);
        chk("t5_m0_quiet", 32'(m0_rsp_valid), 32'd0);
        chk("t5_fn3_held", 32'(mem_fn3), 32'(FN3_LB));
        step();
        drive_m0(1'b1, 1'b0, FN3_LHU, 32'h2, '0);
        @(negedge clk);
        if (m0_req_ready) exp0_q.push_back(32'h000080A1);
        chk("t5_m0_ready", 32'(m0_req_ready), 32'd1);
        step();
        drive_m0(1'b0, 1'b0, FN3_LW, '0, '0);
        step();

        // 6: reset during RD_RESP drops the response
        drive_m0(1'b1, 1'b0, FN3_LH, 32'h14, '0);
        @(negedge clk);
        chk("t6_ready", 32'(m0_req_ready), 32'd1);
        step();
        drive_m0(1'b0, 1'b0, FN3_LW, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rsp_dropped", 32'(m0_rsp_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t6_state", 32'(dut.state), 32'(IDLE));
        chk("t6_mem_we", 32'(mem_we), 32'd0);
        chk("t6_mem_fn3", 32'(mem_fn3), 32'(FN3_LW));
        chk("t6_mem_addr", mem_addr, 32'd0);
        chk("t6_rsp", {30'd0, m0_rsp_valid, m1_rsp_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        chk("q0_drained", 32'(exp0_q.size()), 32'd0);
        chk("q1_drained", 32'(exp1_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
